axi4lite_dma_copy: RTL and testbench

- AXI4-Lite initiator on the system crossbar. It copies a block of 64-bit words from a source address to a destination address, for example flash to SRAM at boot or SRAM to an Ethernet buffer.
- It takes a master port on `axilxbar`, alongside the core's ifetch and data ports.
- It is controlled by a simple start/done sideband driven by a platform register block.
- One word is in flight at a time: read, then write, then the next word.

---
 rtl/axi4lite_dma_copy.sv | 188 ++++++++++++++++++
 tb/tb_axi4lite_dma_copy.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_dma_copy.sv
// axi4lite_dma_copy: AXI4-Lite initiator that copies 64-bit words one at a time (read, write, next).
// Build option AXI4LITE_DMA_FILL_EN adds a fill mode that writes a latched pattern instead of copying.
`ifndef ALEN
`define ALEN 48
`endif

module axi4lite_dma_copy #(
    parameter int ADDR_WIDTH = `ALEN,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    start,
`ifdef AXI4LITE_DMA_FILL_EN
    input  logic                    fill,
    input  logic [DATA_WIDTH-1:0]   fill_pattern,
`endif
    input  logic [ADDR_WIDTH-1:0]   src_addr,
    input  logic [ADDR_WIDTH-1:0]   dst_addr,
    input  logic [LEN_WIDTH-1:0]    len_words,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [2:0]              m_arprot,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [2:0]              m_awprot,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_ADDR = 3'd1;
    localparam logic [2:0] ST_RD_DATA = 3'd2;
    localparam logic [2:0] ST_WR      = 3'd3;
    localparam logic [2:0] ST_WR_RESP = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(7);
    localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(8);

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] cur_src;
    logic [ADDR_WIDTH-1:0] cur_dst;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  aw_done;
    logic                  w_done;
    logic                  err_q;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  fill_mode;
    logic [2:0]            start_state;
    logic [2:0]            next_word_state;
    logic [DATA_WIDTH-1:0] start_data;

`ifdef AXI4LITE_DMA_FILL_EN
    logic fill_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            fill_q <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            fill_q <= fill;
        end
    end

    assign fill_mode   = fill_q;
    assign start_state = fill ? ST_WR : ST_RD_ADDR;
    assign start_data  = fill_pattern;
`else
    assign fill_mode   = 1'b0;
    assign start_state = ST_RD_ADDR;
    assign start_data  = '0;
`endif

    // Fill mode skips the read phase entirely; data_q keeps the pattern for every word.
    assign next_word_state = fill_mode ? ST_WR : ST_RD_ADDR;

    assign aw_hs = m_awvalid && m_awready;
    assign w_hs  = m_wvalid && m_wready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= ST_IDLE;
            cur_src   <= '0;
            cur_dst   <= '0;
            remaining <= '0;
            data_q    <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cur_src   <= src_addr & ALIGN_MASK;
                        cur_dst   <= dst_addr & ALIGN_MASK;
                        remaining <= len_words;
                        data_q    <= start_data;
                        err_q     <= 1'b0;
                        state     <= (len_words == '0) ? ST_DONE : start_state;
                    end
                end
                ST_RD_ADDR: begin
                    if (m_arready) begin
                        state <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (m_rvalid) begin
                        if (m_rresp != 2'b00) begin
                            err_q <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            data_q <= m_rdata;
                            state  <= ST_WR;
                        end
                    end
                end
                ST_WR: begin
                    // AW and W complete independently; move on once both have been accepted.
                    if (aw_hs) begin
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        w_done <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (m_bvalid) begin
                        if (m_bresp != 2'b00) begin
                            err_q <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            cur_src   <= cur_src + WORD_BYTES;
                            cur_dst   <= cur_dst + WORD_BYTES;
                            remaining <= remaining - LEN_WIDTH'(1);
                            state     <= (remaining == LEN_WIDTH'(1)) ? ST_DONE : next_word_state;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != ST_IDLE) && (state != ST_DONE);
    assign done      = (state == ST_DONE);
    assign err       = err_q;

    assign m_araddr  = cur_src;
    assign m_arprot  = 3'b000;
    assign m_arvalid = (state == ST_RD_ADDR);
    assign m_rready  = (state == ST_RD_DATA);
    assign m_awaddr  = cur_dst;
    assign m_awprot  = 3'b000;
    assign m_awvalid = (state == ST_WR) && !aw_done;
    assign m_wdata   = data_q;
    assign m_wstrb   = '1;
    assign m_wvalid  = (state == ST_WR) && !w_done;
    assign m_bready  = (state == ST_WR_RESP);

endmodule

// File: tb/tb_axi4lite_dma_copy.sv
// tb_axi4lite_dma_copy: memory-model AXI4-Lite responder with a write scoreboard around axi4lite_dma_copy.
// Build with AXI4LITE_DMA_FILL_EN defined to also exercise fill mode.
`ifndef ALEN
`define ALEN 48
`endif

module tb_axi4lite_dma_copy;

    localparam int AW = `ALEN;
    localparam int LW = 16;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [LW-1:0] len_words;
`ifdef AXI4LITE_DMA_FILL_EN
    logic          fill;
    logic [63:0]   fill_pattern;
`endif
    logic          busy, done, err;
    logic [AW-1:0] m_araddr, m_awaddr;
    logic [2:0]    m_arprot, m_awprot;
    logic          m_arvalid, m_arready, m_rvalid, m_rready;
    logic          m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [63:0]   m_rdata, m_wdata;
    logic [7:0]    m_wstrb;
    logic [1:0]    m_rresp, m_bresp;

    always #5 aclk = ~aclk;

    axi4lite_dma_copy dut (
        .aclk(aclk), .aresetn(aresetn), .start(start),
`ifdef AXI4LITE_DMA_FILL_EN
        .fill(fill), .fill_pattern(fill_pattern),
`endif
        .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
        .busy(busy), .done(done), .err(err),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    int total = 0;
    int bad = 0;

    logic [63:0] mem [logic [AW-1:0]];
    logic [AW-1:0] sb_addr [$];
    logic [63:0]   sb_data [$];

    bit bp_mode = 1'b0;
    int err_rd_idx = -1;
    int ar_count = 0, r_count = 0, aw_count = 0, w_count = 0, b_count = 0;

    localparam logic [AW-1:0] SRC0 = 48'h180_0000_0000;
    localparam logic [AW-1:0] DST0 = 48'h180_0000_1000;

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rd_mem(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return 64'(a) ^ 64'hA5A5_0000_0000_0000;
    endfunction

    task automatic reset_counts();
        ar_count = 0; r_count = 0; aw_count = 0; w_count = 0; b_count = 0;
    endtask

    // Responder: samples handshakes mid-cycle, updates its drives just after the rising edge.
    initial begin : responder
        logic ar_f, r_f, aw_f, w_f, b_f;
        logic [AW-1:0] ar_a, aw_a, wr_addr, exp_a;
        logic [63:0] w_d, wr_data, exp_d, r_data;
        logic [1:0] r_resp;
        logic prev_ar_st, prev_aw_st, prev_w_st;
        logic [AW-1:0] prev_araddr, prev_awaddr;
        logic [63:0] prev_wdata;
        logic got_aw, got_w, r_pend, b_pend;
        int ar_wait, aw_wait, w_wait;
        prev_ar_st = 0; prev_aw_st = 0; prev_w_st = 0;
        got_aw = 0; got_w = 0; r_pend = 0; b_pend = 0;
        r_data = '0; r_resp = '0; ar_wait = 0; aw_wait = 0; w_wait = 0;
        m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
        m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_bvalid = 1'b0; m_bresp = '0;
        forever begin
            @(negedge aclk);
            if (aresetn) begin
                if (prev_ar_st) begin
                    check_output("ar_hold_valid", m_arvalid, 1);
                    check_output("ar_hold_addr", m_araddr, prev_araddr);
                end
                if (prev_aw_st) begin
                    check_output("aw_hold_valid", m_awvalid, 1);
                    check_output("aw_hold_addr", m_awaddr, prev_awaddr);
                end
                if (prev_w_st) begin
                    check_output("w_hold_valid", m_wvalid, 1);
                    check_output("w_hold_data", m_wdata, prev_wdata);
                end
            end
            ar_f = m_arvalid && m_arready;
            r_f  = m_rvalid && m_rready;
            aw_f = m_awvalid && m_awready;
            w_f  = m_wvalid && m_wready;
            b_f  = m_bvalid && m_bready;
            ar_a = m_araddr; aw_a = m_awaddr; w_d = m_wdata;
            if (ar_f) begin
                check_output("arprot", m_arprot, 0);
                check_output("araddr_align", 64'(m_araddr[2:0]), 0);
            end
            if (aw_f) check_output("awprot", m_awprot, 0);
            if (w_f) check_output("wstrb", m_wstrb, 8'hFF);
            prev_ar_st = aresetn && m_arvalid && !m_arready;
            prev_aw_st = aresetn && m_awvalid && !m_awready;
            prev_w_st  = aresetn && m_wvalid && !m_wready;
            prev_araddr = m_araddr; prev_awaddr = m_awaddr; prev_wdata = m_wdata;
            @(posedge aclk);
            #1;
            if (!aresetn) begin
                got_aw = 0; got_w = 0; r_pend = 0; b_pend = 0;
                prev_ar_st = 0; prev_aw_st = 0; prev_w_st = 0;
                m_rvalid = 1'b0; m_bvalid = 1'b0;
                m_arready = !bp_mode; m_awready = !bp_mode; m_wready = !bp_mode;
                continue;
            end
            if (r_f) begin r_count++; r_pend = 0; end
            if (ar_f) begin
                r_pend = 1;
                r_data = rd_mem(ar_a);
                r_resp = (ar_count == err_rd_idx) ? 2'b10 : 2'b00;
                ar_count++;
            end
            if (b_f) begin b_count++; b_pend = 0; end
            if (aw_f) begin aw_count++; got_aw = 1; wr_addr = aw_a; end
            if (w_f) begin w_count++; got_w = 1; wr_data = w_d; end
            if (got_aw && got_w) begin
                if (sb_addr.size() == 0) begin
                    check_output("sb_extra_write", 1, 0);
                end else begin
                    exp_a = sb_addr.pop_front();
                    exp_d = sb_data.pop_front();
                    check_output("wr_addr", wr_addr, exp_a);
                    check_output("wr_data", wr_data, exp_d);
                end
                mem[wr_addr] = wr_data;
                b_pend = 1; got_aw = 0; got_w = 0;
            end
            if (!bp_mode) m_arready = 1'b1;
            else if (ar_f) begin m_arready = 1'b0; ar_wait = $urandom_range(0, 5); end
            else if (!m_arready && m_arvalid) begin
                if (ar_wait == 0) m_arready = 1'b1; else ar_wait--;
            end
            // On the second word the address is held off until its data has been taken.
            if (!bp_mode) m_awready = 1'b1;
            else if (aw_count == 1 && w_count == 1) m_awready = 1'b0;
            else if (aw_f) begin m_awready = 1'b0; aw_wait = $urandom_range(0, 5); end
            else if (!m_awready && m_awvalid) begin
                if (aw_wait == 0) m_awready = 1'b1; else aw_wait--;
            end
            if (!bp_mode) m_wready = 1'b1;
            else if (w_f) begin m_wready = 1'b0; w_wait = $urandom_range(0, 5); end
            else if (!m_wready && m_wvalid) begin
                if (w_wait == 0) m_wready = 1'b1; else w_wait--;
            end
            m_rvalid = r_pend; m_rdata = r_data; m_rresp = r_resp;
            m_bvalid = b_pend; m_bresp = 2'b00;
        end
    end

    task automatic apply_stimulus(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] n,
                                  input int exp_words, input logic fl, input logic [63:0] pat);
        for (int i = 0; i < exp_words; i++) begin
            sb_addr.push_back(d + AW'(8 * i));
            sb_data.push_back(fl ? pat : rd_mem(s + AW'(8 * i)));
        end
        @(posedge aclk);
        #1;
        start = 1'b1; src_addr = s; dst_addr = d; len_words = n;
`ifdef AXI4LITE_DMA_FILL_EN
        fill = fl; fill_pattern = pat;
`endif
        @(posedge aclk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int busy_cycles);
        bit seen = 0;
        busy_cycles = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge aclk);
            if (done) begin seen = 1; break; end
            if (busy) busy_cycles++;
        end
        check_output({tag, "_done_seen"}, 64'(seen), 1);
        if (seen) begin
            @(negedge aclk);
            check_output({tag, "_done_width"}, done, 0);
            check_output({tag, "_busy_after"}, busy, 0);
        end
    endtask

    initial begin : main
        int bc;
        bit seen;
        start = 1'b0; src_addr = '0; dst_addr = '0; len_words = '0;
`ifdef AXI4LITE_DMA_FILL_EN
        fill = 1'b0; fill_pattern = '0;
`endif
        repeat (3) @(negedge aclk);
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_err", err, 0);
        check_output("rst_arvalid", m_arvalid, 0);
        check_output("rst_rready", m_rready, 0);
        check_output("rst_awvalid", m_awvalid, 0);
        check_output("rst_wvalid", m_wvalid, 0);
        check_output("rst_bready", m_bready, 0);
        @(posedge aclk);
        #3;
        aresetn = 1'b1;

        // Zero-wait three-word copy
        mem[SRC0] = 64'h1111_1111_1111_1111;
        mem[SRC0 + 8] = 64'h2222_2222_2222_2222;
        mem[SRC0 + 16] = 64'h3333_3333_3333_3333;
        reset_counts();
        apply_stimulus(SRC0, DST0, 3, 3, 1'b0, '0);
        wait_done("copy", bc);
        check_output("copy_busy_cycles", bc, 12);
        check_output("copy_err", err, 0);
        check_output("copy_ar_count", ar_count, 3);
        check_output("copy_b_count", b_count, 3);
        check_output("copy_sb_empty", sb_addr.size(), 0);
        check_output("copy_mem0", rd_mem(DST0), 64'h1111_1111_1111_1111);
        check_output("copy_mem1", rd_mem(DST0 + 8), 64'h2222_2222_2222_2222);
        check_output("copy_mem2", rd_mem(DST0 + 16), 64'h3333_3333_3333_3333);

        // Random backpressure, unaligned inputs
        bp_mode = 1'b1;
        reset_counts();
        apply_stimulus(48'h180_0000_0105, 48'h180_0000_1106, 4, 0, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            sb_addr.push_back(48'h180_0000_1100 + AW'(8 * i));
            sb_data.push_back(rd_mem(48'h180_0000_0100 + AW'(8 * i)));
        end
        wait_done("bp", bc);
        check_output("bp_b_count", b_count, 4);
        check_output("bp_aw_count", aw_count, 4);
        check_output("bp_err", err, 0);
        check_output("bp_sb_empty", sb_addr.size(), 0);
        bp_mode = 1'b0;
        repeat (2) @(negedge aclk);

        // Read error on the third word aborts; next good copy clears err
        err_rd_idx = 2;
        reset_counts();
        apply_stimulus(SRC0, 48'h180_0000_1800, 5, 2, 1'b0, '0);
        wait_done("rerr", bc);
        check_output("rerr_err", err, 1);
        check_output("rerr_ar_count", ar_count, 3);
        check_output("rerr_aw_count", aw_count, 2);
        check_output("rerr_sb_empty", sb_addr.size(), 0);
        err_rd_idx = -1;
        reset_counts();
        apply_stimulus(SRC0, 48'h180_0000_1900, 1, 1, 1'b0, '0);
        check_output("rerr_cleared_on_start", err, 0);
        wait_done("recover", bc);
        check_output("recover_err", err, 0);
        check_output("recover_mem", rd_mem(48'h180_0000_1900), 64'h1111_1111_1111_1111);

        // len=0, then a start during the done pulse must be ignored
        reset_counts();
        apply_stimulus(SRC0, 48'h180_0000_5000, 0, 0, 1'b0, '0);
        @(negedge aclk);
        check_output("len0_done", done, 1);
        check_output("len0_busy", busy, 0);
        start = 1'b1; len_words = 2;
        @(posedge aclk);
        #1;
        start = 1'b0;
        @(negedge aclk);
        check_output("start_in_done_busy", busy, 0);
        check_output("start_in_done_done", done, 0);
        repeat (4) @(negedge aclk);
        check_output("len0_ar_count", ar_count, 0);
        check_output("len0_aw_count", aw_count, 0);

        // Start while busy is ignored
        reset_counts();
        apply_stimulus(SRC0, 48'h180_0000_3000, 2, 2, 1'b0, '0);
        repeat (2) @(posedge aclk);
        #1;
        start = 1'b1; dst_addr = 48'h180_0000_4000; len_words = 7;
        @(posedge aclk);
        #1;
        start = 1'b0;
        wait_done("busy_start", bc);
        repeat (6) @(negedge aclk);
        check_output("busy_start_aw_count", aw_count, 2);
        check_output("busy_start_idle", busy, 0);
        check_output("busy_start_no_write", 64'(mem.exists(48'h180_0000_4000)), 0);
        check_output("busy_start_sb_empty", sb_addr.size(), 0);

        // Asynchronous reset while the write address is valid
        reset_counts();
        apply_stimulus(SRC0, 48'h180_0000_6000, 3, 3, 1'b0, '0);
        seen = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge aclk);
            if (m_awvalid) begin seen = 1; break; end
        end
        check_output("arst_aw_seen", 64'(seen), 1);
        #2;
        aresetn = 1'b0;
        #1;
        check_output("arst_awvalid", m_awvalid, 0);
        check_output("arst_wvalid", m_wvalid, 0);
        check_output("arst_busy", busy, 0);
        repeat (2) @(posedge aclk);
        #3;
        aresetn = 1'b1;
        sb_addr.delete();
        sb_data.delete();
        check_output("arst_no_write", 64'(mem.exists(48'h180_0000_6000)), 0);
        reset_counts();
        apply_stimulus(SRC0 + 8, 48'h180_0000_7000, 1, 1, 1'b0, '0);
        wait_done("post_rst", bc);
        check_output("post_rst_aw_count", aw_count, 1);
        check_output("post_rst_mem", rd_mem(48'h180_0000_7000), 64'h2222_2222_2222_2222);

`ifdef AXI4LITE_DMA_FILL_EN
        // Pattern fill: no read traffic at all
        reset_counts();
        apply_stimulus(SRC0, 48'h180_0000_2000, 2, 2, 1'b1, 64'hDEAD_BEEF_CAFE_F00D);
        wait_done("fill", bc);
        check_output("fill_ar_count", ar_count, 0);
        check_output("fill_aw_count", aw_count, 2);
        check_output("fill_err", err, 0);
        check_output("fill_mem0", rd_mem(48'h180_0000_2000), 64'hDEAD_BEEF_CAFE_F00D);
        check_output("fill_mem1", rd_mem(48'h180_0000_2008), 64'hDEAD_BEEF_CAFE_F00D);
        fill = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
